// File: rtl/sprite_anim_if.sv
// sprite_anim_if
// Bundles the player/timing inputs and the registered sprite outputs of the
// sprite animation sequencer.
//   frame_tick   : one-cycle pulse per video frame (start of vertical blank)
//   move_left    : level, player holds left
//   move_right   : level, player holds right
//   jump         : pulse or level, jump request
//   sprite_state : {row[1:0], frame_idx[1:0]} tile index to the position mux
//   facing_left  : direction of the last walk
//   in_jump      : high while the jump animation plays
//   anim_step    : one-cycle pulse when sprite_state takes a new value
// The master modport drives the inputs (player/timing side); the slave
// modport is the sequencer itself.
interface sprite_anim_if;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       jump;
    logic [3:0] sprite_state;
    logic       facing_left;
    logic       in_jump;
    logic       anim_step;

    modport master (
        output frame_tick, move_left, move_right, jump,
        input  sprite_state, facing_left, in_jump, anim_step
    );

    modport slave (
        input  frame_tick, move_left, move_right, jump,
        output sprite_state, facing_left, in_jump, anim_step
    );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl
// Animation sequencer for a 64x64 sprite sheet. A frame-tick divider produces
// an animation step every FRAMES_PER_STEP frames; on each step the FSM picks
// the animation row (idle, walk right, walk left, jump) from player inputs and
// advances or restarts the frame index. All outputs are registered and change
// only on a step, so a tile never changes mid-frame.
// Ports:
//   clk   : pixel clock, rising edge
//   reset : synchronous, active-high
//   bus   : sprite_anim_if.slave (inputs frame_tick/move_left/move_right/jump,
//           outputs sprite_state/facing_left/in_jump/anim_step)
// Parameter FRAMES_PER_STEP (1..63, default 6): frame ticks per animation step.
// Build option SPRITE_JUMP_EN: when defined, the jump row, the latched jump
// request and in_jump are implemented; otherwise jump is ignored and in_jump
// is tied low.
module sprite_anim_ctrl #(
    parameter int FRAMES_PER_STEP = 6
) (
    input  logic          clk,
    input  logic          reset,
    sprite_anim_if.slave  bus
);

    localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WALK_R = 2'd1;
    localparam logic [1:0] ST_WALK_L = 2'd2;
`ifdef SPRITE_JUMP_EN
    localparam logic [1:0] ST_JUMP   = 2'd3;
`endif

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       frame_idx_q, frame_idx_d;
    logic             facing_left_q, facing_left_d;
    logic             anim_step_q, anim_step_d;
    logic             step;
    logic [1:0]       walk_mode;
    logic [1:0]       next_mode;

    // Frame divider: a step is the frame tick that completes a full count.
    always_comb begin
        step      = bus.frame_tick && (div_cnt_q == DIV_W'(FRAMES_PER_STEP - 1));
        div_cnt_d = div_cnt_q;
        if (bus.frame_tick) begin
            div_cnt_d = step ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    // Mode selection. Opposing directions cancel to idle. A running jump
    // holds its row until its last frame; only then are inputs looked at
    // again, and the jump input itself is not honoured while jumping.
`ifdef SPRITE_JUMP_EN
    logic jump_pending_q, jump_pending_d;
    logic in_jump_q, in_jump_d;
`endif

    always_comb begin
        walk_mode = ST_IDLE;
        if (bus.move_right && !bus.move_left) begin
            walk_mode = ST_WALK_R;
        end else if (bus.move_left && !bus.move_right) begin
            walk_mode = ST_WALK_L;
        end
`ifdef SPRITE_JUMP_EN
        if (state_q == ST_JUMP) begin
            next_mode = (frame_idx_q != 2'd3) ? ST_JUMP : walk_mode;
        end else if (bus.jump || jump_pending_q) begin
            next_mode = ST_JUMP;
        end else begin
            next_mode = walk_mode;
        end
`else
        next_mode = walk_mode;
`endif
    end

    // Step update: same row advances the frame, a new row restarts at 0.
    always_comb begin
        state_d       = state_q;
        frame_idx_d   = frame_idx_q;
        facing_left_d = facing_left_q;
        anim_step_d   = step;
        if (step) begin
            state_d     = next_mode;
            frame_idx_d = (next_mode == state_q) ? frame_idx_q + 2'd1 : 2'd0;
            if (next_mode == ST_WALK_L) begin
                facing_left_d = 1'b1;
            end else if (next_mode == ST_WALK_R) begin
                facing_left_d = 1'b0;
            end
        end
    end

`ifdef SPRITE_JUMP_EN
    // A jump request outside the jump row is latched until the step that
    // enters the jump consumes it.
    always_comb begin
        jump_pending_d = jump_pending_q;
        if (state_q != ST_JUMP) begin
            if (step && next_mode == ST_JUMP) begin
                jump_pending_d = 1'b0;
            end else if (bus.jump) begin
                jump_pending_d = 1'b1;
            end
        end
        in_jump_d = (state_d == ST_JUMP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jump_pending_q <= 1'b0;
            in_jump_q      <= 1'b0;
        end else begin
            jump_pending_q <= jump_pending_d;
            in_jump_q      <= in_jump_d;
        end
    end

    assign bus.in_jump = in_jump_q;
`else
    assign bus.in_jump = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            state_q       <= ST_IDLE;
            frame_idx_q   <= 2'd0;
            facing_left_q <= 1'b0;
            anim_step_q   <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            state_q       <= state_d;
            frame_idx_q   <= frame_idx_d;
            facing_left_q <= facing_left_d;
            anim_step_q   <= anim_step_d;
        end
    end

    assign bus.sprite_state = {state_q, frame_idx_q};
    assign bus.facing_left  = facing_left_q;
    assign bus.anim_step    = anim_step_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb_sprite_anim_ctrl
// Directed scenarios followed by randomized traffic for sprite_anim_ctrl with
// FRAMES_PER_STEP=2. Every clock is compared against a behavioural model of
// the animation rules; the jump rules are modelled only when SPRITE_JUMP_EN
// is defined, matching the build of the design.
module tb_sprite_anim_ctrl;

    localparam int FPS = 2;
`ifdef SPRITE_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   step_count;

    sprite_anim_if bus_if ();

    sprite_anim_ctrl #(.FRAMES_PER_STEP(FPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 walk right, 2 walk left, 3 jump.
    int m_ticks;
    int m_mode;
    int m_frame;
    bit m_pend;
    bit m_face;
    bit m_step;

    task automatic modelClock(input bit rst, input bit ft, input bit ml,
                              input bit mr, input bit jp);
        int  nxt;
        bit  stp;
        if (rst) begin
            m_ticks = 0; m_mode = 0; m_frame = 0;
            m_pend = 0; m_face = 0; m_step = 0;
            return;
        end
        stp = 0;
        if (ft) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == FPS) begin
                stp = 1;
                m_ticks = 0;
            end
        end
        if (stp) begin
            if (JUMP_EN && m_mode == 3 && m_frame < 3) nxt = 3;
            else if (JUMP_EN && m_mode != 3 && (jp || m_pend)) nxt = 3;
            else if (mr && !ml) nxt = 1;
            else if (ml && !mr) nxt = 2;
            else nxt = 0;
            if (nxt == 3 && m_mode != 3) m_pend = 0;
            else if (JUMP_EN && jp && m_mode != 3) m_pend = 1;
            m_frame = (nxt == m_mode) ? (m_frame + 1) % 4 : 0;
            if (nxt == 1) m_face = 0;
            if (nxt == 2) m_face = 1;
            m_mode = nxt;
        end else if (JUMP_EN && jp && m_mode != 3) begin
            m_pend = 1;
        end
        m_step = stp;
    endtask

    task automatic checkOutput();
        logic [3:0] exp_state;
        logic       exp_jump;
        exp_state = 4'(m_mode * 4 + m_frame);
        exp_jump  = (m_mode == 3);
        checks++;
        assert (bus_if.sprite_state === exp_state) else begin
            errors++;
            $error("[TB] FAIL sprite_state observed=%0d expected=%0d", bus_if.sprite_state, exp_state);
        end
        checks++;
        assert (bus_if.facing_left === m_face) else begin
            errors++;
            $error("[TB] FAIL facing_left observed=%0b expected=%0b", bus_if.facing_left, m_face);
        end
        checks++;
        assert (bus_if.in_jump === exp_jump) else begin
            errors++;
            $error("[TB] FAIL in_jump observed=%0b expected=%0b", bus_if.in_jump, exp_jump);
        end
        checks++;
        assert (bus_if.anim_step === m_step) else begin
            errors++;
            $error("[TB] FAIL anim_step observed=%0b expected=%0b", bus_if.anim_step, m_step);
        end
        if (bus_if.anim_step === 1'b1) step_count++;
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after.
    task automatic applyStimulus(input bit rst, input bit ft, input bit ml,
                                 input bit mr, input bit jp);
        reset             = rst;
        bus_if.frame_tick = ft;
        bus_if.move_left  = ml;
        bus_if.move_right = mr;
        bus_if.jump       = jp;
        @(posedge clk);
        modelClock(rst, ft, ml, mr, jp);
        #1;
        checkOutput();
    endtask

    task automatic frameTicks(input int n, input bit ml, input bit mr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 1, ml, mr, 0);
            applyStimulus(0, 0, ml, mr, 0);
            applyStimulus(0, 0, ml, mr, 0);
        end
    endtask

    initial begin
        bit ml_r, mr_r, jp_r, ft_r, rst_r;
        checks = 0;
        errors = 0;
        step_count = 0;
        modelClock(1, 0, 0, 0, 0);

        // Reset, with a coincident tick and jump that must lose to reset.
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkValue("reset_state", int'(bus_if.sprite_state), 0);

        // Idle cycling: 8 ticks give 1,2,3,0 with four step pulses.
        step_count = 0;
        frameTicks(8, 0, 0);
        checkValue("idle_state", int'(bus_if.sprite_state), 0);
        checkValue("idle_steps", step_count, 4);

        // Walk right then left, release, and both held.
        frameTicks(2, 0, 1);
        checkValue("walk_r_first", int'(bus_if.sprite_state), 4);
        frameTicks(2, 0, 1);
        checkValue("walk_r_second", int'(bus_if.sprite_state), 5);
        frameTicks(2, 1, 0);
        checkValue("walk_l_first", int'(bus_if.sprite_state), 8);
        checkValue("walk_l_facing", int'(bus_if.facing_left), 1);
        frameTicks(6, 1, 0);
        frameTicks(2, 0, 0);
        checkValue("release_state", int'(bus_if.sprite_state), 0);
        checkValue("release_facing", int'(bus_if.facing_left), 1);
        frameTicks(2, 1, 1);
        checkValue("both_held", int'(bus_if.sprite_state), 1);

        // Jump from walk right at state 5, with a pulse latched between ticks.
        frameTicks(4, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        frameTicks(2, 1, 0);
        applyStimulus(0, 0, 1, 0, 1);
        frameTicks(6, 1, 0);
        frameTicks(2, 0, 1);

        // Jump requested in the same cycle as a step, then reset mid-jump.
        frameTicks(1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        frameTicks(4, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkValue("reset_mid_jump", int'(bus_if.sprite_state), 0);
        frameTicks(2, 0, 0);
        checkValue("after_reset", int'(bus_if.sprite_state), 1);

        // Randomized traffic; the jump input is held low on the last jump
        // frame, where a fresh request could arguably be taken either way.
        ml_r = 0;
        mr_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) ml_r = ~ml_r;
            if ($urandom_range(0, 15) == 0) mr_r = ~mr_r;
            ft_r  = ($urandom_range(0, 3) == 0);
            jp_r  = ($urandom_range(0, 24) == 0);
            rst_r = ($urandom_range(0, 299) == 0);
            if (m_mode == 3 && m_frame == 3) jp_r = 0;
            applyStimulus(rst_r, ft_r, ml_r, mr_r, jp_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
